// File: rtl/rv32_pkg.sv
// rv32_pkg: state and grant encodings shared by the memory bus arbiter and its timeout helper.
package rv32_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_I,
        ARB_BUSY_D
    } arb_state_t;

    localparam logic ARB_GRANT_INSTR = 1'b0;
    localparam logic ARB_GRANT_DATA  = 1'b1;

    function automatic arb_state_t arb_busy_state(input logic grant);
        return grant ? ARB_BUSY_D : ARB_BUSY_I;
    endfunction

endpackage

// File: rtl/rv32_mod_bus_timeout.sv
// rv32_mod_bus_timeout: counts unanswered busy cycles and flags expiry; constant 0 when disabled.
module rv32_mod_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = clk ^ reset ^ clear ^ run;
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(TIMEOUT_CYCLES + 1);
            logic [W-1:0] cnt_q, cnt_d;
            // clear wins so a handoff or timeout cycle restarts the count for the next owner
            always_comb begin
                cnt_d = clear ? '0 : (run ? cnt_q + W'(1) : cnt_q);
            end
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
            assign expired = run && (cnt_q == W'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/rv32_mod_bus_arbiter.sv
// rv32_mod_bus_arbiter: shares one memory port between instruction fetch and the LSU,
// with locked per-transaction grants, zero-bubble handoff and an optional response timeout.
module rv32_mod_bus_arbiter
    import rv32_pkg::*;
#(
    parameter int DATA_PRIORITY  = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_ack,
    output logic        instr_err,
    output logic [31:0] instr_data_o,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_data_i,
    output logic        data_ack,
    output logic        data_err,
    output logic [31:0] data_data_o,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_o,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] mem_data_i
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       busy, grant, run, expired, done, clear, other_req, ack_pulse, err_pulse;

    assign busy  = state_q != ARB_IDLE;
    assign grant = (state_q == ARB_BUSY_D) ? ARB_GRANT_DATA : ARB_GRANT_INSTR;
    assign run   = busy && !mem_ack && !mem_err;

    rv32_mod_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .run    (run),
        .expired(expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        done         = busy && (mem_ack || mem_err || expired);
        other_req    = (grant == ARB_GRANT_DATA) ? instr_req : data_req;
        clear        = !busy || done;
        if (!busy) begin
            if (instr_req && data_req) begin
                state_d = arb_busy_state((DATA_PRIORITY != 0) ? ARB_GRANT_DATA : !last_grant_q);
            end else if (instr_req) begin
                state_d = ARB_BUSY_I;
            end else if (data_req) begin
                state_d = ARB_BUSY_D;
            end
        end else if (done) begin
            // the completing port's own req is still high this cycle and is deliberately ignored
            last_grant_d = grant;
            state_d      = other_req ? arb_busy_state(!grant) : ARB_IDLE;
        end
    end

    always_comb begin
        mem_req    = busy;
        mem_wr     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = 32'h0;
        mem_data_o = 32'h0;
        if (state_q == ARB_BUSY_I) begin
            mem_be   = 4'b1111;
            mem_addr = instr_addr;
        end else if (state_q == ARB_BUSY_D) begin
            mem_wr     = data_wr;
            mem_be     = data_be;
            mem_addr   = data_addr;
            mem_data_o = data_data_i;
        end
        err_pulse = busy && (mem_err || expired);
        ack_pulse = busy && mem_ack && !mem_err;
        instr_ack = ack_pulse && (grant == ARB_GRANT_INSTR);
        instr_err = err_pulse && (grant == ARB_GRANT_INSTR);
        data_ack  = ack_pulse && (grant == ARB_GRANT_DATA);
        data_err  = err_pulse && (grant == ARB_GRANT_DATA);
    end

    assign instr_data_o = mem_data_i;
    assign data_data_o  = mem_data_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= ARB_GRANT_DATA;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_rv32_mod_bus_arbiter.sv
// tb_rv32_mod_bus_arbiter: directed plus randomized scoreboard bench for two arbiter configurations
// (instance 0: data priority with 8-cycle timeout; instance 1: round-robin, no timeout).
module tb_rv32_mod_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        ireq  [2];
    logic [31:0] iaddr [2];
    logic        iack  [2];
    logic        ierr  [2];
    logic [31:0] idat  [2];
    logic        dreq  [2];
    logic        dwr   [2];
    logic [3:0]  dbe   [2];
    logic [31:0] daddr [2];
    logic [31:0] dwd   [2];
    logic        dack  [2];
    logic        derr  [2];
    logic [31:0] ddat  [2];
    logic        mreq  [2];
    logic        mwr   [2];
    logic [3:0]  mbe   [2];
    logic [31:0] maddr [2];
    logic [31:0] mwd   [2];
    logic        mack  [2];
    logic        merr  [2];
    logic [31:0] mdi   [2];

    rv32_mod_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)) u0 (
        .clk(clk), .reset(reset),
        .instr_req(ireq[0]), .instr_addr(iaddr[0]), .instr_ack(iack[0]), .instr_err(ierr[0]),
        .instr_data_o(idat[0]),
        .data_req(dreq[0]), .data_wr(dwr[0]), .data_be(dbe[0]), .data_addr(daddr[0]),
        .data_data_i(dwd[0]), .data_ack(dack[0]), .data_err(derr[0]), .data_data_o(ddat[0]),
        .mem_req(mreq[0]), .mem_wr(mwr[0]), .mem_be(mbe[0]), .mem_addr(maddr[0]),
        .mem_data_o(mwd[0]), .mem_ack(mack[0]), .mem_err(merr[0]), .mem_data_i(mdi[0])
    );

    rv32_mod_bus_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset),
        .instr_req(ireq[1]), .instr_addr(iaddr[1]), .instr_ack(iack[1]), .instr_err(ierr[1]),
        .instr_data_o(idat[1]),
        .data_req(dreq[1]), .data_wr(dwr[1]), .data_be(dbe[1]), .data_addr(daddr[1]),
        .data_data_i(dwd[1]), .data_ack(dack[1]), .data_err(derr[1]), .data_data_o(ddat[1]),
        .mem_req(mreq[1]), .mem_wr(mwr[1]), .mem_be(mbe[1]), .mem_addr(maddr[1]),
        .mem_data_o(mwd[1]), .mem_ack(mack[1]), .mem_err(merr[1]), .mem_data_i(mdi[1])
    );

    // expected requester-side completion: port 0 = fetch, 1 = LSU; 'when' is the pulse cycle
    typedef struct {
        int          port;
        bit          err;
        logic [31:0] data;
        int          when;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   ndone [2];

    task automatic push(input int d, input int port, input bit err, input logic [31:0] data,
                        input int when);
        exp_t e;
        e = '{port, err, data, when};
        if (d == 0) sbq0.push_back(e);
        else sbq1.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // monitor: every requester pulse is matched against the oldest expectation for that instance
    initial begin
        logic ia, ie, da, de, ok, empty;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                ia = iack[d];
                ie = ierr[d];
                da = dack[d];
                de = derr[d];
                if (ia || ie || da || de) begin
                    n_cmp++;
                    empty = (d == 0) ? (sbq0.size() == 0) : (sbq1.size() == 0);
                    if (empty) begin
                        n_fail++;
                        $display("FAIL pulse_unexpected dut%0d: got i_ack=%b i_err=%b d_ack=%b d_err=%b, expected no pulse (cycle %0d)",
                                 d, ia, ie, da, de, cyc);
                    end else begin
                        if (d == 0) e = sbq0.pop_front();
                        else e = sbq1.pop_front();
                        ok = (int'(ia) + int'(ie) + int'(da) + int'(de) == 1)
                          && ((da || de) == (e.port == 1))
                          && ((ie || de) == e.err)
                          && (e.when == cyc)
                          && (e.err || ((e.port == 1 ? ddat[d] : idat[d]) == e.data));
                        if (!ok) begin
                            n_fail++;
                            $display("FAIL pulse dut%0d: got i_ack=%b i_err=%b d_ack=%b d_err=%b idat=%h ddat=%h cycle=%0d, expected port=%0d err=%0d data=%h cycle=%0d",
                                     d, ia, ie, da, de, idat[d], ddat[d], cyc, e.port, e.err, e.data, e.when);
                        end
                    end
                end
            end
        end
    end

    task automatic drv(input int d, input int p);
        int  w;
        bit  got;
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(1, 4)) nxt();
            if (p == 0) begin
                iaddr[d] = $urandom;
                ireq[d]  = 1'b1;
            end else begin
                dwr[d]   = 1'($urandom_range(0, 1));
                dbe[d]   = 4'($urandom_range(0, 15));
                daddr[d] = $urandom;
                dwd[d]   = $urandom;
                dreq[d]  = 1'b1;
            end
            w   = 0;
            got = 1'b0;
            while (!got && w < 300) begin
                mid();
                got = (p == 0) ? (iack[d] || ierr[d]) : (dack[d] || derr[d]);
                w++;
                if (!got) nxt();
            end
            if (!got) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rnd_wait dut%0d port%0d: got no completion in 300 cycles, expected one", d, p);
            end
            nxt();
            if (p == 0) ireq[d] = 1'b0;
            else dreq[d] = 1'b0;
        end
        ndone[d]++;
    endtask

    // memory plus transaction-level reference: who owns the bus, when it answers, and with what
    task automatic model(input int d);
        int          owner = -1;
        int          lg = 1;
        int          start = 0;
        int          resp = -1;
        int          kind = 0;
        int          k;
        int          lim;
        logic [31:0] rdata = 32'h0;
        lim = cyc + 20000;
        while ((ndone[d] < 2 || owner >= 0) && cyc < lim) begin
            mid();
            k = cyc;
            if (owner >= 0) begin
                chk($sformatf("rnd%0d_busy_req", d), 32'(mreq[d]), 32'h1);
                if (k == start) begin
                    chk($sformatf("rnd%0d_addr", d), maddr[d], owner == 1 ? daddr[d] : iaddr[d]);
                    chk($sformatf("rnd%0d_wr", d), 32'(mwr[d]), owner == 1 ? 32'(dwr[d]) : 32'h0);
                    chk($sformatf("rnd%0d_be", d), 32'(mbe[d]), owner == 1 ? 32'(dbe[d]) : 32'hF);
                    chk($sformatf("rnd%0d_wdata", d), mwd[d], owner == 1 ? dwd[d] : 32'h0);
                    kind = $urandom_range(0, 9);
                    if (kind == 9 && d != 0) kind = 0;
                    resp  = (kind == 9) ? k + 7 : k + $urandom_range(1, 3);
                    rdata = $urandom;
                    push(d, owner, kind >= 7, rdata, resp);
                end
                if (k == resp) begin
                    lg = owner;
                    if (owner == 0 ? dreq[d] : ireq[d]) begin
                        owner = 1 - owner;
                        start = k + 1;
                    end else begin
                        owner = -1;
                    end
                end
            end else begin
                chk($sformatf("rnd%0d_idle_req", d), 32'(mreq[d]), 32'h0);
                if (ireq[d] && dreq[d]) owner = (d == 0) ? 1 : 1 - lg;
                else if (ireq[d]) owner = 0;
                else if (dreq[d]) owner = 1;
                if (owner >= 0) start = k + 1;
            end
            nxt();
            mack[d] = (owner >= 0) && (cyc == resp) && (kind <= 6 || kind == 8);
            merr[d] = (owner >= 0) && (cyc == resp) && (kind == 7 || kind == 8);
            mdi[d]  = ((owner >= 0) && (cyc == resp)) ? rdata : $urandom;
            if (owner < 0 && $urandom_range(0, 7) == 0) begin
                mack[d] = 1'($urandom_range(0, 1));
                merr[d] = !mack[d];
            end
        end
        if (cyc >= lim) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rnd%0d_budget: got no drain within 20000 cycles, expected drain", d);
        end
        mack[d] = 1'b0;
        merr[d] = 1'b0;
    endtask

    initial begin
        int k;
        for (int d = 0; d < 2; d++) begin
            ireq[d] = 0; iaddr[d] = 0; dreq[d] = 0; dwr[d] = 0; dbe[d] = 0;
            daddr[d] = 0; dwd[d] = 0; mack[d] = 0; merr[d] = 0; mdi[d] = 0;
            ndone[d] = 0;
        end
        repeat (3) nxt();
        mid();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_req", d), 32'(mreq[d]), 32'h0);
            chk($sformatf("rst%0d_wr", d), 32'(mwr[d]), 32'h0);
            chk($sformatf("rst%0d_be", d), 32'(mbe[d]), 32'h0);
            chk($sformatf("rst%0d_addr", d), maddr[d], 32'h0);
            chk($sformatf("rst%0d_wdata", d), mwd[d], 32'h0);
            chk($sformatf("rst%0d_pulses", d), 32'({iack[d], ierr[d], dack[d], derr[d]}), 32'h0);
        end
        nxt();
        reset = 1'b0;

        // fetch only, two-cycle memory latency
        nxt(); ireq[0] = 1; iaddr[0] = 32'h100; k = cyc;
        mid(); chk("t1_idle_req", 32'(mreq[0]), 32'h0);
        nxt(); mid();
        chk("t1_req", 32'(mreq[0]), 32'h1);
        chk("t1_addr", maddr[0], 32'h100);
        chk("t1_be", 32'(mbe[0]), 32'hF);
        chk("t1_wr", 32'(mwr[0]), 32'h0);
        push(0, 0, 0, 32'h13, k + 3);
        nxt();
        nxt(); mack[0] = 1; mdi[0] = 32'h13;
        mid(); chk("t1_data_ack", 32'(dack[0]), 32'h0);
        nxt(); mack[0] = 0; mdi[0] = 0; ireq[0] = 0;
        mid(); chk("t1_idle_after", 32'(mreq[0]), 32'h0);

        // simultaneous fetch and store with data priority, then handoff
        nxt(); ireq[0] = 1; iaddr[0] = 32'h400;
        dreq[0] = 1; dwr[0] = 1; daddr[0] = 32'h2000; dbe[0] = 4'b0011; dwd[0] = 32'hDEADBEEF;
        k = cyc;
        nxt(); mid();
        chk("t2_req", 32'(mreq[0]), 32'h1);
        chk("t2_wr", 32'(mwr[0]), 32'h1);
        chk("t2_addr", maddr[0], 32'h2000);
        chk("t2_be", 32'(mbe[0]), 32'h3);
        chk("t2_wdata", mwd[0], 32'hDEADBEEF);
        push(0, 1, 0, 32'hCAFE0001, k + 2);
        nxt(); mack[0] = 1; mdi[0] = 32'hCAFE0001;
        mid();
        nxt(); mack[0] = 0; dreq[0] = 0;
        mid();
        chk("t2_handoff_req", 32'(mreq[0]), 32'h1);
        chk("t2_handoff_addr", maddr[0], 32'h400);
        chk("t2_handoff_wr", 32'(mwr[0]), 32'h0);
        chk("t2_handoff_be", 32'(mbe[0]), 32'hF);
        chk("t2_handoff_wdata", mwd[0], 32'h0);
        push(0, 0, 0, 32'h11223344, k + 4);
        nxt(); mack[0] = 1; mdi[0] = 32'h11223344;
        mid();
        nxt(); mack[0] = 0; ireq[0] = 0;
        mid(); chk("t2_idle_after", 32'(mreq[0]), 32'h0);

        // round-robin with both requests held: I, D, I, D
        nxt(); ireq[1] = 1; iaddr[1] = 32'h800;
        dreq[1] = 1; dwr[1] = 0; daddr[1] = 32'h3000; dbe[1] = 4'hF; dwd[1] = 0;
        k = cyc;
        for (int t = 0; t < 4; t++) begin
            nxt(); mack[1] = 0;
            if (t == 3) ireq[1] = 0;
            mid();
            chk($sformatf("t3_grant%0d_addr", t), maddr[1], (t % 2 == 1) ? 32'h3000 : 32'h800);
            push(1, t % 2, 0, 32'h1000 + 32'(t), k + 2 + 2 * t);
            nxt(); mack[1] = 1; mdi[1] = 32'h1000 + 32'(t);
            mid();
        end
        nxt(); mack[1] = 0; dreq[1] = 0;
        mid(); chk("t3_idle_after", 32'(mreq[1]), 32'h0);

        // timeout on an unanswered load, then a late ack
        nxt(); dreq[0] = 1; dwr[0] = 0; daddr[0] = 32'h5000; dbe[0] = 4'hF; k = cyc;
        push(0, 1, 1, 32'h0, k + 8);
        for (int t = 1; t <= 8; t++) begin
            nxt(); mid();
            chk($sformatf("t4_busy%0d", t), 32'(mreq[0]), 32'h1);
        end
        nxt(); dreq[0] = 0;
        mid(); chk("t4_idle_after", 32'(mreq[0]), 32'h0);
        nxt();
        nxt(); mack[0] = 1;
        mid(); chk("t4_late_ack", 32'(dack[0]), 32'h0);
        nxt(); mack[0] = 0;

        // ack and err together: only err reaches the fetch port
        nxt(); ireq[0] = 1; iaddr[0] = 32'h600; k = cyc;
        push(0, 0, 1, 32'h0, k + 2);
        nxt(); mid(); chk("t5_req", 32'(mreq[0]), 32'h1);
        nxt(); mack[0] = 1; merr[0] = 1;
        mid(); chk("t5_iack", 32'(iack[0]), 32'h0);
        nxt(); mack[0] = 0; merr[0] = 0; ireq[0] = 0;
        mid(); chk("t5_idle_after", 32'(mreq[0]), 32'h0);

        // reset during a data transaction
        nxt(); dreq[0] = 1; dwr[0] = 1; daddr[0] = 32'h7000;
        nxt(); mid(); chk("t6_busy", 32'(mreq[0]), 32'h1);
        nxt(); reset = 1;
        mid();
        nxt(); reset = 0; dreq[0] = 0;
        mid(); chk("t6_req_after_reset", 32'(mreq[0]), 32'h0);
        nxt(); mack[0] = 1;
        mid(); chk("t6_dack", 32'(dack[0]), 32'h0);
        nxt(); mack[0] = 0;

        fork
            model(0);
            model(1);
            drv(0, 0);
            drv(0, 1);
            drv(1, 0);
            drv(1, 1);
        join

        repeat (4) nxt();
        chk("sb_drain0", 32'(sbq0.size()), 32'h0);
        chk("sb_drain1", 32'(sbq1.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
